// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter sharing one byte-wide sink among N requesters,
// holding the grant per packet with an idle watchdog that frees a stalled owner.
module uart_tx_arbiter #(
   parameter int N = 4,
   parameter int DATA_W = 8,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        req_valid,
   input  logic [N*DATA_W-1:0] req_data,
   input  logic [N-1:0]        req_last,
   output logic [N-1:0]        req_ready,
   output logic                tx_valid,
   output logic [DATA_W-1:0]   tx_data,
   input  logic                tx_ready,
   output logic [N-1:0]        grant,
   output logic                busy,
   output logic                timeout
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(IDLE_TIMEOUT + 1);
   typedef enum logic {IDLE, OWN} state_t;
   state_t state_q, state_d;
   logic [N-1:0] grant_q, grant_d;
   logic [PW-1:0] ptr_q, ptr_d, g, pick, idx;
   logic [CW-1:0] cnt_q, cnt_d;
   logic timeout_q, to_d, found, xfer;
   always_comb begin
      g = '0;
      tx_data = '0;
      for (int i = 0; i < N; i++)
         if (grant_q[i]) begin
            g = PW'(i);
            tx_data = req_data[i*DATA_W +: DATA_W];
         end
   end
   always_comb begin
      pick = ptr_q;
      idx = '0;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         idx = PW'((int'(ptr_q) + i) % N);
         if (!found && req_valid[idx]) begin
            pick = idx;
            found = 1'b1;
         end
      end
   end
   // a beat presented while rst is high must not be handed to the sink
   assign tx_valid = !rst && |(req_valid & grant_q);
   assign req_ready = rst ? '0 : grant_q & {N{tx_ready}};
   assign xfer = tx_valid && tx_ready;
   assign grant = grant_q;
   assign busy = state_q == OWN;
   assign timeout = timeout_q;
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d = ptr_q;
      cnt_d = '0;
      to_d = 1'b0;
      if (state_q == IDLE) begin
         state_d = |req_valid ? OWN : IDLE;
         grant_d = |req_valid ? N'(1) << pick : '0;
      end else if ((xfer && req_last[g]) || (!req_valid[g] && cnt_q == CW'(IDLE_TIMEOUT - 1))) begin
         state_d = IDLE;
         grant_d = '0;
         ptr_d = g;
         to_d = !req_valid[g];
      end else
         cnt_d = req_valid[g] ? '0 : cnt_q + 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q <= PW'(N - 1);
         cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         timeout_q <= to_d;
      end
   end
   a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized packet traffic checked by a
// scoreboard fed from a transaction-level round-robin model.
module tb_uart_tx_arbiter;
   localparam int N = 4;
   localparam int DW = 8;
   localparam int IT = 16;
   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] req_valid, req_last, req_ready, grant;
   logic [N*DW-1:0] req_data;
   logic tx_valid, tx_ready, busy, timeout;
   logic [DW-1:0] tx_data;
   typedef struct {
      int src;
      logic [DW-1:0] d;
      logic last;
   } beat_t;
   beat_t exp_q[$];
   beat_t src_q[N][$];
   beat_t mq[N][$];
   int checks = 0;
   int errors = 0;
   bit mon_en = 0;
   bit dead = 0;
   beat_t e;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N(N), .DATA_W(DW), .IDLE_TIMEOUT(IT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
      .req_ready(req_ready), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .grant(grant), .busy(busy), .timeout(timeout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, want);
      end
   endtask

   task automatic setd(input int i, input logic [DW-1:0] v);
      req_data[i*DW +: DW] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      req_last = '0;
      req_data = '0;
      tx_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // scoreboard monitor: every sink transfer must match the next expected beat
   always @(negedge clk) begin
      if (mon_en) begin
         if (dead) begin
            checks++;
            if (grant !== '0) begin
               errors++;
               $display("FAIL sb_dead_cycle grant=%b want=0", grant);
            end
            dead = 0;
         end
         if (tx_valid && tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL sb_extra_beat grant=%b data=%h want=none", grant, tx_data);
            end else begin
               e = exp_q.pop_front();
               if (grant !== (N'(1) << e.src) || tx_data !== e.d) begin
                  errors++;
                  $display("FAIL sb_beat grant=%b data=%h want grant=%b data=%h",
                           grant, tx_data, N'(1) << e.src, e.d);
               end
               dead = e.last;
            end
         end
      end
   end

   initial begin
      int n, first, bad, ptr, cyc, len;
      logic [N-1:0] acc;
      bit start[N];
      int bub[N];
      beat_t b;
      logic [2:0] r;

      do_reset();
      @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_req_ready", req_ready, 0);

      // three-beat packet from requester 0
      @(posedge clk); #1;
      req_valid = 4'b0001; setd(0, 8'hA1); tx_ready = 1'b1;
      @(negedge clk);
      chk("pk_arb_latency", grant, 0);
      @(negedge clk);
      chk("pk_grant", grant, 4'b0001);
      chk("pk_busy", busy, 1);
      chk("pk_a1", tx_data, 8'hA1);
      chk("pk_ready", req_ready, 4'b0001);
      @(posedge clk); #1 setd(0, 8'hA2);
      @(negedge clk);
      chk("pk_a2", tx_data, 8'hA2);
      @(posedge clk); #1 setd(0, 8'hA3); req_last = 4'b0001;
      @(negedge clk);
      chk("pk_a3", tx_data, 8'hA3);
      @(posedge clk); #1 req_valid = '0; req_last = '0;
      @(negedge clk);
      chk("pk_release", grant, 0);
      chk("pk_busy_low", busy, 0);

      // all requesting single-beat packets: rotate with a dead cycle between grants
      do_reset();
      @(posedge clk); #1;
      req_valid = 4'hF; req_last = 4'hF; tx_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("rr_seq", grant, (k % 2 == 1) ? (1 << ((k / 2) % N)) : 0);
      end
      @(posedge clk); #1 req_valid = '0; req_last = '0;

      // owner 2 stalls after one beat: watchdog release
      do_reset();
      @(posedge clk); #1;
      req_valid = 4'b0100; setd(2, 8'h55); tx_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("to_grant", grant, 4'b0100);
      chk("to_data", tx_data, 8'h55);
      @(posedge clk); #1 req_valid = '0;
      n = 0;
      first = -1;
      for (int k = 0; k <= 20; k++) begin
         @(negedge clk);
         if (timeout) begin
            n++;
            if (first < 0) first = k;
         end
      end
      chk("to_pulse_count", n, 1);
      chk("to_pulse_pos", first, 16);
      chk("to_grant_released", grant, 0);
      @(posedge clk); #1 req_valid = 4'hF;
      @(negedge clk);
      @(negedge clk);
      chk("to_next_ptr", grant, 4'b1000);

      // owner 1 under 40 cycles of sink backpressure
      do_reset();
      @(posedge clk); #1;
      req_valid = 4'b0010; setd(1, 8'h77); req_last = 4'b0010; tx_ready = 1'b0;
      @(negedge clk);
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (timeout || grant !== 4'b0010 || tx_data !== 8'h77 || req_ready !== 4'b0000 || !tx_valid)
            bad++;
      end
      chk("bp_hold_cycles_bad", bad, 0);
      @(posedge clk); #1 tx_ready = 1'b1;
      @(negedge clk);
      chk("bp_ready", req_ready, 4'b0010);
      @(posedge clk); #1 req_valid = '0; req_last = '0;
      @(negedge clk);
      chk("bp_release", grant, 0);
      chk("bp_no_timeout", timeout, 0);

      // reset on the second beat of a packet from requester 3
      do_reset();
      @(posedge clk); #1;
      req_valid = 4'b1000; setd(3, 8'h31); tx_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rm_beat1", tx_data, 8'h31);
      @(posedge clk); #1 setd(3, 8'h32); rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0; req_valid = 4'hF;
      @(negedge clk);
      chk("rm_grant_cleared", grant, 0);
      chk("rm_tx_valid", tx_valid, 0);
      @(negedge clk);
      chk("rm_first_grant", grant, 4'b0001);

      // non-owners toggle valid/last during a packet from requester 0
      do_reset();
      @(posedge clk); #1;
      tx_ready = 1'b1;
      r = 3'($urandom);
      req_valid = {r, 1'b1};
      r = 3'($urandom);
      req_last = {r, 1'b0};
      setd(0, 8'hC0);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         setd(0, 8'hC0 + 8'(k));
         r = 3'($urandom);
         req_valid = {r, 1'b1};
         r = 3'($urandom);
         req_last = {r, k == 3};
         for (int i = 1; i < N; i++) setd(i, 8'($urandom));
         @(negedge clk);
         chk("no_grant", grant, 4'b0001);
         chk("no_data", tx_data, 8'hC0 + 8'(k));
         chk("no_nonowner_ready", req_ready & 4'b1110, 0);
      end
      @(posedge clk); #1 req_valid = '0; req_last = '0;

      // randomized packet traffic against the round-robin model
      do_reset();
      for (int i = 0; i < N; i++) begin
         start[i] = 1;
         bub[i] = 0;
         for (int p = 0; p < int'($urandom_range(1, 4)); p++) begin
            len = int'($urandom_range(1, 4));
            for (int k = 0; k < len; k++) begin
               b.src = i;
               b.d = 8'($urandom);
               b.last = (k == len - 1);
               src_q[i].push_back(b);
               mq[i].push_back(b);
            end
         end
      end
      ptr = N - 1;
      forever begin
         n = -1;
         for (int k = 1; k <= N; k++)
            if (n < 0 && mq[(ptr + k) % N].size() > 0) n = (ptr + k) % N;
         if (n < 0) break;
         do begin
            b = mq[n].pop_front();
            exp_q.push_back(b);
         end while (!b.last);
         ptr = n;
      end
      mon_en = 1;
      bad = 0;
      cyc = 0;
      acc = '0;
      while (exp_q.size() > 0 && cyc < 4000) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++)
            if (acc[i]) begin
               b = src_q[i].pop_front();
               start[i] = b.last;
            end
         for (int i = 0; i < N; i++)
            if (src_q[i].size() > 0) begin
               setd(i, src_q[i][0].d);
               req_last[i] = src_q[i][0].last;
               req_valid[i] = start[i] || bub[i] >= 3 || $urandom_range(3) != 0;
               bub[i] = req_valid[i] ? 0 : bub[i] + 1;
            end else begin
               setd(i, 8'($urandom));
               req_last[i] = 1'($urandom);
               req_valid[i] = 1'b0;
            end
         tx_ready = $urandom_range(3) != 0;
         @(negedge clk);
         acc = req_valid & req_ready;
         if (timeout) bad++;
         cyc++;
      end
      @(posedge clk); #1 req_valid = '0; req_last = '0;
      repeat (3) @(negedge clk);
      mon_en = 0;
      chk("rand_all_beats_seen", exp_q.size(), 0);
      chk("rand_no_timeout", bad, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
